// File: rtl/date_entry_pkg.sv
`default_nettype none
// ============================================================================
// Package     : date_entry_pkg
// Description : Shared types and constants for the BCD date entry block:
//               FSM state encoding (doubles as field_sel), field indices,
//               packed-BCD field limits and a BCD digit validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package date_entry_pkg;

    // State value is exported directly as field_sel.
    typedef enum logic [1:0] {
        S_MONTH = 2'd0,
        S_DAY   = 2'd1,
        S_YEAR  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int FIELD_MONTH = 0;
    localparam int FIELD_DAY   = 1;
    localparam int FIELD_YEAR  = 2;

    // Limits are packed BCD; once both digits are known to be <= 9 a plain
    // binary compare orders BCD values correctly.
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] DAY_MAX   = 8'h31;
    localparam logic [7:0] YEAR_MAX  = 8'h99;

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_date_entry_if.sv
`default_nettype none
// ============================================================================
// Interface   : bcd_date_entry_if
// Description : User-side and result signals of bcd_date_entry.
//               master : drives KEY/SW, observes results (board / bench)
//               slave  : the date entry block
//   KEY[1:0]    raw active-low buttons, [0]=load, [1]=next/commit
//   SW[7:0]     BCD field value
//   date_o      committed {MM,DD,YY}
//   date_valid  one-cycle commit pulse
//   edit_bcd    working date for preview
//   field_sel   0=month 1=day 2=year 3=done
//   err         last action rejected (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_date_entry_if;
    logic [1:0]  KEY;
    logic [7:0]  SW;
    logic [23:0] date_o;
    logic        date_valid;
    logic [23:0] edit_bcd;
    logic [1:0]  field_sel;
    logic        err;

    modport master (
        output KEY, SW,
        input  date_o, date_valid, edit_bcd, field_sel, err
    );

    modport slave (
        input  KEY, SW,
        output date_o, date_valid, edit_bcd, field_sel, err
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, stability counter and press detector
//               for one active-low push-button. A new level is accepted after
//               DEBOUNCE_CYCLES consecutive samples differing from the current
//               debounced level; a debounced high->low change yields a
//               one-cycle o_press. Reset holds the released (high) state so
//               reset itself never produces a press.
//   clk, rst    clock, synchronous active-high reset
//   i_key_n     raw button, active-low
//   o_press     one-cycle press event
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_n,
    output logic      o_press
);
    localparam int              c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] != r_stable) begin
                // Any sample equal to the current level restarts the count,
                // so only an uninterrupted run is accepted.
                if (r_cnt == c_cnt_last) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                    r_press  <= r_stable & ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;
endmodule
`default_nettype wire

// File: rtl/bcd_date_entry.sv
`default_nettype none
// ============================================================================
// Module      : bcd_date_entry
// Description : Interactive packed-BCD date entry {MM,DD,YY}. KEY0 loads SW
//               into the current field after BCD/range checks, KEY1 advances
//               to the next field and, from the year field, commits the
//               working date to date_o with a one-cycle date_valid pulse.
//   CLK, RST    clock, synchronous active-high reset
//   bus         bcd_date_entry_if.slave (KEY, SW, date_o, date_valid,
//               edit_bcd, field_sel, err)
// Configuration macro: DATE_CALENDAR_CHECK_EN - when defined, the commit also
//               checks the day against the month length (leap year when the
//               BCD year is divisible by 4, 00 included).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_date_entry
    import date_entry_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [23:0] INIT_DATE       = 24'h010100
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    bcd_date_entry_if.slave bus
);
    state_t      r_state, w_state_nxt;
    logic [23:0] r_edit,  w_edit_nxt;
    logic [23:0] r_date,  w_date_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err,   w_err_nxt;
    logic [3:0]  r_loaded, w_loaded_nxt;   // indexed by state; bit 3 unused
    logic        w_load_ev, w_next_ev;
    logic        w_load_ok;
    logic        w_cal_ok;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
        .clk     (CLK),
        .rst     (RST),
        .i_key_n (bus.KEY[0]),
        .o_press (w_load_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk     (CLK),
        .rst     (RST),
        .i_key_n (bus.KEY[1]),
        .o_press (w_next_ev)
    );

    // Field acceptance: digits must be BCD first so the magnitude compare
    // against the BCD limits is meaningful.
    always_comb begin
        w_load_ok = 1'b0;
        case (r_state)
            S_MONTH: w_load_ok = bcd_digits_ok(bus.SW) && (bus.SW != 8'h00) && (bus.SW <= MONTH_MAX);
            S_DAY:   w_load_ok = bcd_digits_ok(bus.SW) && (bus.SW != 8'h00) && (bus.SW <= DAY_MAX);
            S_YEAR:  w_load_ok = bcd_digits_ok(bus.SW) && (bus.SW <= YEAR_MAX);
            default: w_load_ok = 1'b0;
        endcase
    end

`ifdef DATE_CALENDAR_CHECK_EN
    logic [7:0] w_day_limit;
    logic       w_leap;

    always_comb begin
        // Divisible by 4 in BCD: even tens need units 0/4/8, odd tens 2/6.
        if (r_edit[4])
            w_leap = (r_edit[3:0] == 4'd2) || (r_edit[3:0] == 4'd6);
        else
            w_leap = (r_edit[3:0] == 4'd0) || (r_edit[3:0] == 4'd4) || (r_edit[3:0] == 4'd8);
        case (r_edit[23:16])
            8'h04, 8'h06, 8'h09, 8'h11: w_day_limit = 8'h30;
            8'h02:                      w_day_limit = w_leap ? 8'h29 : 8'h28;
            default:                    w_day_limit = DAY_MAX;
        endcase
    end

    assign w_cal_ok = (r_edit[15:8] <= w_day_limit);
`else
    assign w_cal_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_edit_nxt   = r_edit;
        w_date_nxt   = r_date;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = r_err;
        w_loaded_nxt = r_loaded;

        // A load takes priority; a simultaneous next is dropped.
        if (w_load_ev && (r_state != S_DONE)) begin
            if (w_load_ok) begin
                case (r_state)
                    S_MONTH: w_edit_nxt[23:16] = bus.SW;
                    S_DAY:   w_edit_nxt[15:8]  = bus.SW;
                    default: w_edit_nxt[7:0]   = bus.SW;
                endcase
                w_loaded_nxt[r_state] = 1'b1;
                w_err_nxt             = 1'b0;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (w_next_ev) begin
            case (r_state)
                S_MONTH: begin
                    if (!r_loaded[FIELD_MONTH]) w_err_nxt   = 1'b1;
                    else                        w_state_nxt = S_DAY;
                end
                S_DAY: begin
                    if (!r_loaded[FIELD_DAY]) w_err_nxt   = 1'b1;
                    else                      w_state_nxt = S_YEAR;
                end
                S_YEAR: begin
                    if (!r_loaded[FIELD_YEAR] || !w_cal_ok) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_date_nxt  = r_edit;
                        w_valid_nxt = 1'b1;
                        w_err_nxt   = 1'b0;
                    end
                end
                default: begin
                    // Start a fresh pass; the working date is kept as a preview.
                    w_state_nxt  = S_MONTH;
                    w_loaded_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_MONTH;
            r_edit   <= INIT_DATE;
            r_date   <= INIT_DATE;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_loaded <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_edit   <= w_edit_nxt;
            r_date   <= w_date_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_loaded <= w_loaded_nxt;
        end
    end

    assign bus.date_o     = r_date;
    assign bus.date_valid = r_valid;
    assign bus.edit_bcd   = r_edit;
    assign bus.field_sel  = r_state;
    assign bus.err        = r_err;
endmodule
`default_nettype wire
